// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the architectural PC, fetches over a req/ack handshake,
// hands inst/pc to the control stage and halts on misaligned-PC or fetch-timeout faults.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic [31:0] next_pc,
  input  logic        commit,
  input  logic        stall,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    FAULT = 2'b11
  } state_e;

  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_ALIGN = 2'b01;
  localparam logic [1:0] CODE_TMO   = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retired_q, retired_d;
  logic        inst_valid_q, inst_valid_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic        pc_aligned;

  assign wait_inc   = wait_q + 8'd1;
  assign pc_aligned = (pc_q[1:0] == 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    retired_d    = retired_q;
    inst_valid_d = inst_valid_q;
    fault_code_d = fault_code_q;
    wait_d       = wait_q;
    imem_req     = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        // A misaligned PC faults before any request is ever raised for it.
        if (!pc_aligned) begin
          state_d      = FAULT;
          fault_code_d = CODE_ALIGN;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            inst_d       = imem_rdata;
            inst_valid_d = 1'b1;
            state_d      = EXEC;
          end else begin
            wait_d = wait_inc;
            if (wait_inc == TIMEOUT_C) begin
              state_d      = FAULT;
              fault_code_d = CODE_TMO;
            end
          end
        end
      end
      EXEC: begin
        if (commit && !stall) begin
          pc_d         = next_pc;
          inst_valid_d = 1'b0;
          retired_d    = retired_q + 32'd1;
          wait_d       = 8'd0;
          state_d      = FETCH;
        end
      end
      FAULT: inst_valid_d = 1'b0;
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      retired_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      fault_code_q <= CODE_NONE;
      wait_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      retired_q    <= retired_d;
      inst_valid_q <= inst_valid_d;
      fault_code_q <= fault_code_d;
      wait_q       <= wait_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign retired    = retired_q;
  assign fault      = (state_q == FAULT);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed plus randomized bench for inst_fetch_unit against a transaction-level model
// of the fetch/commit sequence (expected PC, instruction word and retire count).
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          TMO    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic [31:0] next_pc;
  logic        commit;
  logic        stall;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  int tests = 0;
  int fails = 0;

  // Model state: what the control stage should currently see.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_ret;

  inst_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .pc(pc),
    .inst_valid(inst_valid), .next_pc(next_pc), .commit(commit), .stall(stall),
    .fault(fault), .fault_code(fault_code), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_exec(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_inst"}, inst, m_inst);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_ret"}, retired, m_ret);
  endtask

  // Sits in FETCH for dly non-ack cycles then acks; checks req/addr stable throughout.
  task automatic fetch_one(input int dly, input logic [31:0] data);
    logic [31:0] junk;
    for (int i = 0; i <= dly; i++) begin
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_valid", 32'(inst_valid), 32'd0);
      junk = $urandom;
      imem_ack   = (i == dly);
      imem_rdata = (i == dly) ? data : junk;
      tick();
    end
    imem_ack = 1'b0;
    m_inst   = data;
    chk_exec("fetched");
  endtask

  // Holds commit under stall for nstall cycles, then lets it through.
  task automatic commit_to(input logic [31:0] npc, input int nstall);
    commit  = 1'b1;
    next_pc = npc;
    stall   = 1'b1;
    for (int i = 0; i < nstall; i++) begin
      tick();
      chk_exec("stalled");
    end
    stall = 1'b0;
    tick();
    commit = 1'b0;
    m_pc   = npc;
    m_ret  = m_ret + 32'd1;
    chk("commit_pc", pc, m_pc);
    chk("commit_ret", retired, m_ret);
    chk("commit_valid", 32'(inst_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_ret", retired, 32'd0);
    tick();
    rst_n  = 1'b1;
    m_pc   = RST_PC;
    m_inst = 32'd0;
    m_ret  = 32'd0;
    // BOOT cycle: no request yet.
    chk("boot_req", 32'(imem_req), 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] held;
    int          d;
    int          s;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    next_pc    = 32'd0;
    commit     = 1'b0;
    stall      = 1'b0;
    rst_n      = 1'b0;
    tick();

    // Reset, boot, immediate ack.
    do_reset();
    fetch_one(0, 32'h2008_0005);

    // Sequential commit, then a branch target.
    commit_to(32'h0040_0004, 0);
    fetch_one(0, 32'h1234_5678);
    commit_to(32'h0040_0010, 0);
    chk("branch_addr", imem_addr, 32'h0040_0010);
    chk("ret_two", retired, 32'd2);

    // Delayed ack, then acks in EXEC must be ignored.
    fetch_one(3, 32'hCAFE_0001);
    for (int i = 0; i < 2; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      chk_exec("exec_ack_ignored");
    end
    imem_ack = 1'b0;

    // Five stalled commits, then the commit goes through once.
    commit_to(32'h0040_0100, 5);

    // Randomized fetch/commit traffic.
    for (int n = 0; n < 25; n++) begin
      d = $urandom_range(0, TMO - 1);
      r = $urandom;
      fetch_one(d, r);
      s = $urandom_range(0, 3);
      for (int i = 0; i < s; i++) begin
        stall = $urandom_range(0, 1) == 1;
        tick();
        chk_exec("idle");
      end
      stall = 1'b0;
      r = $urandom;
      r[1:0] = 2'b00;
      commit_to(r, $urandom_range(0, 2));
    end

    // Misaligned next_pc: fault without ever requesting it.
    fetch_one(0, 32'h0000_0020);
    commit_to(32'h0040_0002, 0);
    chk("mis_noreq", 32'(imem_req), 32'd0);
    tick();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_code", 32'(fault_code), 32'd1);
    chk("mis_pc", pc, 32'h0040_0002);
    chk("mis_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 6; i++) begin
      imem_ack   = $urandom_range(0, 1) == 1;
      commit     = $urandom_range(0, 1) == 1;
      stall      = $urandom_range(0, 1) == 1;
      next_pc    = $urandom;
      imem_rdata = $urandom;
      tick();
      chk("fault_hold", {fault_code, 1'b0, fault, imem_req, inst_valid, pc[25:0]},
          {2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 26'h0400002});
      chk("fault_ret", retired, m_ret);
      chk("fault_inst", inst, 32'h0000_0020);
    end
    imem_ack = 1'b0;
    commit   = 1'b0;
    stall    = 1'b0;

    // Fetch timeout.
    do_reset();
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_req", 32'(imem_req), 32'd1);
      chk("tmo_fault", 32'(fault), 32'd0);
      tick();
    end
    chk("tmo_fault_set", 32'(fault), 32'd1);
    chk("tmo_code", 32'(fault_code), 32'd2);
    chk("tmo_req_drop", 32'(imem_req), 32'd0);
    tick();
    chk("tmo_hold", 32'(fault_code), 32'd2);

    // Asynchronous reset in the middle of a fetch; ack during/after reset ignored.
    do_reset();
    chk("mid_req", 32'(imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_req_drop", 32'(imem_req), 32'd0);
    chk("mid_fault", 32'(fault), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    tick();
    chk("inrst_valid", 32'(inst_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("boot_ack_valid", 32'(inst_valid), 32'd0);
    chk("boot_ack_inst", inst, 32'd0);
    imem_ack = 1'b0;
    held = 32'h2008_0005;
    fetch_one(1, held);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
